// File: rtl/inst_fifo_if.sv
// inst_fifo_if: fetch/decode side signals of the instruction buffer.
// The slave modport is the buffer itself; the master modport is the fetch/decode pair.
// Optional: with INST_FIFO_ERR_CHK_EN defined, the sticky protocol-error flag is carried too.
interface inst_fifo_if;
   // Control
   logic        flush;
   // Push side (slot 1 is the older instruction)
   logic        write_en1;
   logic        write_en2;
   logic [31:0] write_inst1;
   logic [31:0] write_inst2;
   logic [31:0] write_addr1;
   logic [31:0] write_addr2;
   // Pop side (head and head+1)
   logic        read_en1;
   logic        read_en2;
   logic [31:0] read_inst1;
   logic [31:0] read_inst2;
   logic [31:0] read_addr1;
   logic [31:0] read_addr2;
   logic        read_valid1;
   logic        read_valid2;
   // Occupancy status
   logic        empty;
   logic        fifo_full;
`ifdef INST_FIFO_ERR_CHK_EN
   logic        err_sticky;

   modport slave (
      input  flush,
      input  write_en1, write_en2, write_inst1, write_inst2, write_addr1, write_addr2,
      input  read_en1, read_en2,
      output read_inst1, read_inst2, read_addr1, read_addr2, read_valid1, read_valid2,
      output empty, fifo_full, err_sticky
   );

   modport master (
      output flush,
      output write_en1, write_en2, write_inst1, write_inst2, write_addr1, write_addr2,
      output read_en1, read_en2,
      input  read_inst1, read_inst2, read_addr1, read_addr2, read_valid1, read_valid2,
      input  empty, fifo_full, err_sticky
   );
`else
   modport slave (
      input  flush,
      input  write_en1, write_en2, write_inst1, write_inst2, write_addr1, write_addr2,
      input  read_en1, read_en2,
      output read_inst1, read_inst2, read_addr1, read_addr2, read_valid1, read_valid2,
      output empty, fifo_full
   );

   modport master (
      output flush,
      output write_en1, write_en2, write_inst1, write_inst2, write_addr1, write_addr2,
      output read_en1, read_en2,
      input  read_inst1, read_inst2, read_addr1, read_addr2, read_valid1, read_valid2,
      input  empty, fifo_full
   );
`endif
endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: dual-write / dual-read instruction buffer between fetch and decode.
// Up to two {inst, pc} pairs are pushed and up to two popped per cycle; reads are
// first-word-fall-through from head and head+1. fifo_full asks fetch to hold the PC
// whenever fewer than two slots are free, so an honoured 2-wide push never overflows.
// Optional: define INST_FIFO_ERR_CHK_EN to add err_sticky, a flag that records any
// dropped push, over-count pop, or slot-2 request without slot 1.
module inst_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   inst_fifo_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(DEPTH - 1);

   // Storage: instruction word and PC per entry
   logic [31:0] r_mem_inst [DEPTH];
   logic [31:0] r_mem_addr [DEPTH];

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic [PTR_W-1:0] w_head_p1;
   logic [PTR_W-1:0] w_tail_p1;
   logic [1:0]       w_req_pop;
   logic [1:0]       w_req_push;
   logic [1:0]       w_npop;
   logic [1:0]       w_npush;
   logic [CNT_W-1:0] w_free;
   logic [PTR_W-1:0] w_head_d;
   logic [PTR_W-1:0] w_tail_d;
   logic [CNT_W-1:0] w_count_d;

   // Pointer arithmetic wraps naturally because DEPTH is a power of two
   assign w_head_p1 = r_head + PTR_W'(1);
   assign w_tail_p1 = r_tail + PTR_W'(1);

   // Requested transfer sizes; slot 2 only counts when slot 1 is also requested
   assign w_req_pop  = {1'b0, bus.read_en1}  + {1'b0, bus.read_en1 & bus.read_en2};
   assign w_req_push = {1'b0, bus.write_en1} + {1'b0, bus.write_en1 & bus.write_en2};

   // Pop clamp to occupancy, then push clamp to the space left after this cycle's pop
   always_comb begin
      w_npop  = w_req_pop;
      w_npush = w_req_push;
      w_free  = '0;
      if (CNT_W'(w_req_pop) > r_count) begin
         // Only reachable with count < 2, so the low bits are the whole count
         w_npop = r_count[1:0];
      end
      w_free = DEPTH_C - r_count + CNT_W'(w_npop);
      if (CNT_W'(w_req_push) > w_free) begin
         // Only reachable with free < 2; slot 1 is kept ahead of slot 2
         w_npush = w_free[1:0];
      end
   end

   // Next-state pointers and occupancy
   always_comb begin
      w_head_d  = r_head + PTR_W'(w_npop);
      w_tail_d  = r_tail + PTR_W'(w_npush);
      w_count_d = r_count + CNT_W'(w_npush) - CNT_W'(w_npop);
   end

   // Pointer and occupancy registers; flush discards everything, including same-cycle traffic
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (bus.flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= w_head_d;
         r_tail  <= w_tail_d;
         r_count <= w_count_d;
      end
   end

   // Entry writes at tail / tail+1; array contents need no reset since valid is count-based
   always_ff @(posedge clk) begin
      if (!rst && !bus.flush) begin
         if (w_npush != 2'd0) begin
            r_mem_inst[r_tail] <= bus.write_inst1;
            r_mem_addr[r_tail] <= bus.write_addr1;
         end
         if (w_npush == 2'd2) begin
            r_mem_inst[w_tail_p1] <= bus.write_inst2;
            r_mem_addr[w_tail_p1] <= bus.write_addr2;
         end
      end
   end

   // Fall-through read ports and status decoded from registered occupancy
   always_comb begin
      bus.read_inst1  = r_mem_inst[r_head];
      bus.read_addr1  = r_mem_addr[r_head];
      bus.read_inst2  = r_mem_inst[w_head_p1];
      bus.read_addr2  = r_mem_addr[w_head_p1];
      bus.read_valid1 = (r_count != '0);
      bus.read_valid2 = (r_count >= CNT_W'(2));
      bus.empty       = (r_count == '0);
      bus.fifo_full   = (r_count >= FULL_TH);
   end

`ifdef INST_FIFO_ERR_CHK_EN
   logic r_err_sticky;
   logic w_err_event;

   // Any clamped or malformed request this cycle
   always_comb begin
      w_err_event = (w_npush != w_req_push)
                  | (w_npop != w_req_pop)
                  | (bus.write_en2 & ~bus.write_en1)
                  | (bus.read_en2 & ~bus.read_en1);
   end

   // Sticky error flag; only rst clears it so a redirect cannot hide a past violation
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_sticky <= 1'b0;
      end else if (w_err_event) begin
         r_err_sticky <= 1'b1;
      end
   end

   assign bus.err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo: directed self-checking bench for inst_fifo (DEPTH=16).
// Covers reset, pair push/pop, fill to the full threshold and beyond, pointer wrap,
// flush with concurrent traffic, and clamped edge requests. Honours INST_FIFO_ERR_CHK_EN.
module tb_inst_fifo;

   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   inst_fifo_if u_bus ();

   inst_fifo #(
      .DEPTH (16)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      u_bus.flush       = 1'b0;
      u_bus.write_en1   = 1'b0;
      u_bus.write_en2   = 1'b0;
      u_bus.write_inst1 = 32'h0;
      u_bus.write_inst2 = 32'h0;
      u_bus.write_addr1 = 32'h0;
      u_bus.write_addr2 = 32'h0;
      u_bus.read_en1    = 1'b0;
      u_bus.read_en2    = 1'b0;
   endtask

   task automatic set_push(input logic en1, input logic en2,
                           input logic [31:0] i1, input logic [31:0] a1,
                           input logic [31:0] i2, input logic [31:0] a2);
      u_bus.write_en1   = en1;
      u_bus.write_en2   = en2;
      u_bus.write_inst1 = i1;
      u_bus.write_addr1 = a1;
      u_bus.write_inst2 = i2;
      u_bus.write_addr2 = a2;
   endtask

   task automatic set_pop(input logic en1, input logic en2);
      u_bus.read_en1 = en1;
      u_bus.read_en2 = en2;
   endtask

   initial begin
      logic [31:0] pc;
      logic [31:0] pop_pc;

      // Reset then idle
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rst_empty",  32'(u_bus.empty),       32'd1);
         check("rst_valid1", 32'(u_bus.read_valid1), 32'd0);
         check("rst_full",   32'(u_bus.fifo_full),   32'd0);
`ifdef INST_FIFO_ERR_CHK_EN
         check("rst_err", 32'(u_bus.err_sticky), 32'd0);
`endif
         step();
      end

      // Push a pair, then pop it
      set_push(1'b1, 1'b1, 32'h24010001, 32'hbfc00000, 32'h24020002, 32'hbfc00004);
      check("pair_no_same_cycle", 32'(u_bus.read_valid1), 32'd0);
      step();
      idle_inputs();
      check("pair_valid1", 32'(u_bus.read_valid1), 32'd1);
      check("pair_valid2", 32'(u_bus.read_valid2), 32'd1);
      check("pair_inst1",  u_bus.read_inst1, 32'h24010001);
      check("pair_addr1",  u_bus.read_addr1, 32'hbfc00000);
      check("pair_inst2",  u_bus.read_inst2, 32'h24020002);
      check("pair_addr2",  u_bus.read_addr2, 32'hbfc00004);
      check("pair_empty",  32'(u_bus.empty), 32'd0);
      set_pop(1'b1, 1'b1);
      step();
      idle_inputs();
      check("pair_pop_empty", 32'(u_bus.empty), 32'd1);

      // Fill: entry k has inst 0x100+k, pc 0x1000+4k
      for (int k = 0; k < 7; k++) begin
         set_push(1'b1, 1'b1, 32'h100 + 32'(2 * k), 32'h1000 + 32'(8 * k),
                  32'h101 + 32'(2 * k), 32'h1004 + 32'(8 * k));
         step();
      end
      idle_inputs();
      check("fill14_full",   32'(u_bus.fifo_full),   32'd0);
      check("fill14_valid2", 32'(u_bus.read_valid2), 32'd1);
      set_push(1'b1, 1'b0, 32'h10e, 32'h1038, 32'h0, 32'h0);
      step();
      idle_inputs();
      check("fill15_full", 32'(u_bus.fifo_full), 32'd1);
      set_pop(1'b1, 1'b0);
      step();
      idle_inputs();
      check("pop14_full",  32'(u_bus.fifo_full), 32'd0);
      check("pop14_addr1", u_bus.read_addr1, 32'h1004);
`ifdef INST_FIFO_ERR_CHK_EN
      check("fill_err_clear", 32'(u_bus.err_sticky), 32'd0);
`endif
      // Back to 16, then a push that must be dropped entirely
      set_push(1'b1, 1'b1, 32'h10f, 32'h103c, 32'h110, 32'h1040);
      step();
      check("fill16_full", 32'(u_bus.fifo_full), 32'd1);
      set_push(1'b1, 1'b1, 32'h111, 32'h1044, 32'h112, 32'h1048);
      step();
      idle_inputs();
      check("drop_full", 32'(u_bus.fifo_full), 32'd1);
`ifdef INST_FIFO_ERR_CHK_EN
      check("drop_err_set", 32'(u_bus.err_sticky), 32'd1);
`endif
      for (int j = 0; j < 8; j++) begin
         check("drain_addr1", u_bus.read_addr1, 32'h1004 + 32'(8 * j));
         check("drain_addr2", u_bus.read_addr2, 32'h1008 + 32'(8 * j));
         check("drain_inst1", u_bus.read_inst1, 32'h101 + 32'(2 * j));
         set_pop(1'b1, 1'b1);
         step();
         idle_inputs();
      end
      check("drain_empty", 32'(u_bus.empty), 32'd1);

      // Wrap-around: concurrent dual push and dual pop, PCs sequential by 4
      pc     = 32'hbfc00000;
      pop_pc = 32'hbfc00000;
      set_push(1'b1, 1'b1, ~pc, pc, ~(pc + 32'd4), pc + 32'd4);
      step();
      pc = pc + 32'd8;
      for (int i = 0; i < 39; i++) begin
         set_push(1'b1, 1'b1, ~pc, pc, ~(pc + 32'd4), pc + 32'd4);
         set_pop(1'b1, 1'b1);
         check("wrap_valid2", 32'(u_bus.read_valid2), 32'd1);
         check("wrap_addr1",  u_bus.read_addr1, pop_pc);
         check("wrap_addr2",  u_bus.read_addr2, pop_pc + 32'd4);
         check("wrap_inst1",  u_bus.read_inst1, ~pop_pc);
         step();
         pc     = pc + 32'd8;
         pop_pc = pop_pc + 32'd8;
      end
      idle_inputs();
      check("wrap_last_addr1", u_bus.read_addr1, pop_pc);
      check("wrap_last_addr2", u_bus.read_addr2, pop_pc + 32'd4);
      set_pop(1'b1, 1'b1);
      step();
      idle_inputs();
      check("wrap_empty", 32'(u_bus.empty), 32'd1);

      // Flush mid-stream with concurrent push and pop
      for (int k = 0; k < 3; k++) begin
         set_push(1'b1, 1'b1, 32'h0, 32'hbfc00300 + 32'(8 * k),
                  32'h0, 32'hbfc00304 + 32'(8 * k));
         step();
      end
      idle_inputs();
      check("pre_flush_valid2", 32'(u_bus.read_valid2), 32'd1);
      u_bus.flush = 1'b1;
      set_push(1'b1, 1'b1, 32'h11111111, 32'hbfc00340, 32'h22222222, 32'hbfc00344);
      set_pop(1'b1, 1'b0);
      step();
      idle_inputs();
      check("flush_empty",  32'(u_bus.empty),       32'd1);
      check("flush_valid1", 32'(u_bus.read_valid1), 32'd0);
      set_push(1'b1, 1'b0, 32'h3c1dbfc0, 32'hbfc00380, 32'h0, 32'h0);
      step();
      idle_inputs();
      check("post_flush_addr1",  u_bus.read_addr1, 32'hbfc00380);
      check("post_flush_inst1",  u_bus.read_inst1, 32'h3c1dbfc0);
      check("post_flush_valid1", 32'(u_bus.read_valid1), 32'd1);
      check("post_flush_valid2", 32'(u_bus.read_valid2), 32'd0);

      // Edge: dual pop with a single entry pops only one
      set_pop(1'b1, 1'b1);
      step();
      idle_inputs();
      check("edge_pop_empty", 32'(u_bus.empty), 32'd1);
`ifdef INST_FIFO_ERR_CHK_EN
      check("edge_err", 32'(u_bus.err_sticky), 32'd1);
      u_bus.flush = 1'b1;
      step();
      idle_inputs();
      check("edge_err_after_flush", 32'(u_bus.err_sticky), 32'd1);
`endif
      // Slot-2 push without slot 1 is ignored
      set_push(1'b0, 1'b1, 32'h0, 32'hdeadbeef, 32'h0, 32'hdeadbeef);
      step();
      idle_inputs();
      check("we2_only_empty", 32'(u_bus.empty), 32'd1);
      // Pop on empty is a no-op; the following single push must give count 1
      set_pop(1'b1, 1'b1);
      step();
      idle_inputs();
      set_push(1'b1, 1'b0, 32'h0, 32'hbfc00400, 32'h0, 32'h0);
      step();
      idle_inputs();
      check("after_empty_pop_valid1", 32'(u_bus.read_valid1), 32'd1);
      check("after_empty_pop_valid2", 32'(u_bus.read_valid2), 32'd0);
      check("after_empty_pop_addr1",  u_bus.read_addr1, 32'hbfc00400);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
- Dual-write, dual-read instruction buffer between the fetch stage (PC register + I-cache response) and decode.
- Accepts up to two fetched instructions with their PCs per cycle and presents up to two oldest entries to dual-issue decode.
- Drives fifo_full back to the PC register so fetch holds the PC when space is short.
- Flushed on exception, taken branch, or flush_all redirects.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all entries this cycle.
- write_en1  input  1  push slot 1 (older instruction).
- write_en2  input  1  push slot 2; only honoured when write_en1=1.
- write_inst1  input  32  instruction word, slot 1.
- write_inst2  input  32  instruction word, slot 2.
- write_addr1  input  32  PC of slot 1.
- write_addr2  input  32  PC of slot 2.
- read_en1  input  1  decode consumes head entry.
- read_en2  input  1  decode consumes head+1; only honoured when read_en1=1.
- read_inst1  output  32  instruction at head.
- read_inst2  output  32  instruction at head+1.
- read_addr1  output  32  PC at head.
- read_addr2  output  32  PC at head+1.
- read_valid1  output  1  count >= 1.
- read_valid2  output  1  count >= 2.
- empty  output  1  count == 0.
- fifo_full  output  1  count >= DEPTH-1, i.e. fewer than 2 free slots.

Behaviour:
- Storage:
  - DEPTH x 64-bit register array (inst, addr); head pointer, tail pointer, count register (PTR_W+1 bits).
  - Pointers wrap modulo DEPTH.
- Reset: head=tail=count=0.
  - Outputs after reset: empty=1, read_valid1/2=0, fifo_full=0.
  - read_inst/addr are don't-care; the bench checks them only when the matching valid is 1.
- Reads are first-word-fall-through and combinational from array[head] and array[head+1 mod DEPTH].
  - A pushed entry is readable the cycle after the push, never in the same cycle.
- Pop count per cycle:
  - npop = read_en1 + (read_en1 & read_en2), clamped to count.
  - Requests beyond count are ignored.
  - head advances by npop.
- Push count per cycle:
  - npush = write_en1 + (write_en1 & write_en2), clamped to the free space (DEPTH - count + npop).
  - Slot 1 is written at tail, slot 2 at tail+1.
  - Entries beyond free space are dropped; slot 1 is always kept before slot 2.
  - tail advances by npush.
- Simultaneous push and pop:
  - Both occur; count_next = count + npush - npop.
  - A pop frees space usable by the same-cycle push.
- flush:
  - Highest priority after rst.
  - head=tail=count=0 next cycle; same-cycle pushes and pops are discarded.
- Full/empty:
  - fifo_full is a registered-state decode (from count), asserted at count in {DEPTH-1, DEPTH}.
  - The producer must not push while fifo_full=1. With the threshold at DEPTH-1, a 2-wide push never overflows when the producer honours fifo_full.
  - Pop with count=0 is a no-op.
- Ordering: strict FIFO; slot 1 is older than slot 2 on both push and pop.

Optional Feature:
- Macro: INST_FIFO_ERR_CHK_EN.
- When defined:
  - Adds output err_sticky (1 bit), reset to 0 by rst only; flush does not clear it.
  - Sets when any push is dropped for lack of space, or a pop is requested beyond count, or write_en2=1 with write_en1=0, or read_en2=1 with read_en1=0.
- When undefined:
  - The port is absent.
  - These conditions are silently clamped or ignored as described in Behaviour.

Test Plan:
- Reset then idle:
  - Response: empty=1, read_valid1=0, fifo_full=0 for 5 cycles.
- Push pair, then pop pair:
  - Stimulus: push (0x24010001 @0xbfc00000, 0x24020002 @0xbfc00004).
  - Next cycle: read_valid2=1, read_inst1=0x24010001, read_addr2=0xbfc00004.
  - Then pop 2: empty=1.
- Fill with DEPTH=16:
  - Stimulus: 7 dual pushes, then 1 single push.
  - Response: count=15, fifo_full=1.
  - Then pop 1 (count=14): fifo_full=0 next cycle.
- Wrap-around:
  - Stimulus: interleave dual push and dual pop for 40 cycles with incrementing PCs from 0xbfc00000.
  - Response: popped PCs strictly +4 sequential, with no gaps or duplicates across the pointer wrap.
- Flush mid-stream:
  - Stimulus: count=6; assert flush together with a dual push and read_en1.
  - Response: next cycle empty=1. The next pushed PC 0xbfc00380 appears as read_addr1.
- Edge requests:
  - Stimulus: read_en2=1, read_en1=1 with count=1.
  - Response: only 1 entry is popped; empty=1 next cycle. With INST_FIFO_ERR_CHK_EN, err_sticky=1 and it stays 1 through a flush.
